// File: rtl/useq_pkg.sv
// Shared definitions for the microcode sequencer: sequencing opcodes, FSM states
// and helpers that place the microinstruction fields from the block parameters.
package useq_pkg;

    localparam logic [2:0] SEQ_NEXT = 3'd0;
    localparam logic [2:0] SEQ_JUMP = 3'd1;
    localparam logic [2:0] SEQ_BRC  = 3'd2;
    localparam logic [2:0] SEQ_CALL = 3'd3;
    localparam logic [2:0] SEQ_RET  = 3'd4;
    localparam logic [2:0] SEQ_END  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    // Field layout, MSB to LSB: seq_op[2:0], csel, target, cw.
    function automatic int csel_width(int num_cond);
        return $clog2(num_cond);
    endfunction

    function automatic int tgt_lsb(int cw_w);
        return cw_w;
    endfunction

    function automatic int csel_lsb(int cw_w, int uaddr_w);
        return cw_w + uaddr_w;
    endfunction

    function automatic int op_lsb(int cw_w, int uaddr_w, int num_cond);
        return cw_w + uaddr_w + $clog2(num_cond);
    endfunction

    function automatic int uinstr_width(int cw_w, int uaddr_w, int num_cond);
        return cw_w + uaddr_w + $clog2(num_cond) + 3;
    endfunction

endpackage

// File: rtl/useq_sequencer_if.sv
// Bundle of the sequencer's opcode handshake, ROM port, datapath control and
// dispatch-table write port.
interface useq_sequencer_if #(
    parameter int OPCODE_W = 8,
    parameter int UADDR_W  = 6,
    parameter int CW_W     = 16,
    parameter int NUM_COND = 4
) ();
    import useq_pkg::*;

    localparam int UI_W = uinstr_width(CW_W, UADDR_W, NUM_COND);

    // Handshake: an opcode transfers on a rising clk edge where op_valid && op_ready;
    // op_valid may stay high across cycles without being consumed while op_ready is low.
    logic                op_valid;
    logic                op_ready;
    logic [OPCODE_W-1:0] opcode;
    logic [UADDR_W-1:0]  uaddr;
    logic [UI_W-1:0]     uinstr;
    logic [NUM_COND-1:0] cond;
    logic                stall;
    logic                ctrl_valid;
    logic [CW_W-1:0]     ctrl_word;
    logic                done;
    logic                illegal;
    logic                fault;
    logic                fault_clr;
    logic                tbl_we;
    logic [OPCODE_W-1:0] tbl_idx;
    logic [UADDR_W-1:0]  tbl_addr;
    logic                tbl_vld;
    state_e              dbg_state;

    modport slave (
        input  op_valid, opcode, uinstr, cond, stall, fault_clr,
               tbl_we, tbl_idx, tbl_addr, tbl_vld,
        output op_ready, uaddr, ctrl_valid, ctrl_word, done, illegal, fault,
               dbg_state
    );

    modport master (
        output op_valid, opcode, uinstr, cond, stall, fault_clr,
               tbl_we, tbl_idx, tbl_addr, tbl_vld,
        input  op_ready, uaddr, ctrl_valid, ctrl_word, done, illegal, fault,
               dbg_state
    );

endinterface

// File: rtl/useq_dispatch_table.sv
// Programmable opcode -> micro-address dispatch table with a registered array
// and combinational lookup; reset restores the legacy 0x01..0x03 map.
module useq_dispatch_table #(
    parameter int OPCODE_W = 8,
    parameter int UADDR_W  = 6
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                we,
    input  logic [OPCODE_W-1:0] wr_idx,
    input  logic [UADDR_W-1:0]  wr_addr,
    input  logic                wr_vld,
    input  logic [OPCODE_W-1:0] rd_idx,
    output logic                rd_vld,
    output logic [UADDR_W-1:0]  rd_addr
);
    localparam int N = 2 ** OPCODE_W;

    logic [N-1:0]       vld_q, vld_d;
    logic [UADDR_W-1:0] addr_q [N];
    logic [UADDR_W-1:0] addr_d [N];

    always_comb begin
        vld_d  = vld_q;
        addr_d = addr_q;
        if (we) begin
            vld_d[wr_idx]  = wr_vld;
            addr_d[wr_idx] = wr_addr;
        end
    end

    // Reads come from the registered array, so a same-cycle write is not visible.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N; i++) begin
                vld_q[i]  <= (i >= 1 && i <= 3);
                addr_q[i] <= (i >= 1 && i <= 3) ? UADDR_W'(i - 1) : '0;
            end
        end else begin
            vld_q  <= vld_d;
            addr_q <= addr_d;
        end
    end

    assign rd_vld  = vld_q[rd_idx];
    assign rd_addr = addr_q[rd_idx];

endmodule

// File: rtl/useq_sequencer.sv
// Microcode sequencer: dispatches accepted opcodes through the table, then walks
// the external microcode ROM with next/jump/branch/call/return/end sequencing.
module useq_sequencer
    import useq_pkg::*;
#(
    parameter int                 OPCODE_W    = 8,
    parameter int                 UADDR_W     = 6,
    parameter int                 CW_W        = 16,
    parameter int                 NUM_COND    = 4,
    parameter int                 STACK_DEPTH = 2,
    parameter logic [UADDR_W-1:0] TRAP_ADDR   = 6'h3F
) (
    input  logic             clk,
    input  logic             reset_n,
    useq_sequencer_if.slave  bus
);
    localparam int CSEL_W   = csel_width(NUM_COND);
    localparam int TGT_LSB  = tgt_lsb(CW_W);
    localparam int CSEL_LSB = csel_lsb(CW_W, UADDR_W);
    localparam int OP_LSB   = op_lsb(CW_W, UADDR_W, NUM_COND);
    localparam int SP_W     = $clog2(STACK_DEPTH + 1);

    state_e             state_q, state_d;
    logic [UADDR_W-1:0] uaddr_q, uaddr_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [UADDR_W-1:0] stack_q [STACK_DEPTH];
    logic [UADDR_W-1:0] stack_d [STACK_DEPTH];

    logic [2:0]         seq_op;
    logic [CSEL_W-1:0]  csel;
    logic [UADDR_W-1:0] target, uaddr_inc, pop_addr, lkp_addr;
    logic [CW_W-1:0]    cw;
    logic               lkp_vld, op_ready, accept, ctrl_valid, done;

    assign seq_op    = bus.uinstr[OP_LSB +: 3];
    assign csel      = bus.uinstr[CSEL_LSB +: CSEL_W];
    assign target    = bus.uinstr[TGT_LSB +: UADDR_W];
    assign cw        = bus.uinstr[0 +: CW_W];
    assign uaddr_inc = uaddr_q + UADDR_W'(1);

    useq_dispatch_table #(
        .OPCODE_W (OPCODE_W),
        .UADDR_W  (UADDR_W)
    ) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .we      (bus.tbl_we),
        .wr_idx  (bus.tbl_idx),
        .wr_addr (bus.tbl_addr),
        .wr_vld  (bus.tbl_vld),
        .rd_idx  (bus.opcode),
        .rd_vld  (lkp_vld),
        .rd_addr (lkp_addr)
    );

    always_comb begin
        state_d    = state_q;
        uaddr_d    = uaddr_q;
        sp_d       = sp_q;
        stack_d    = stack_q;
        op_ready   = 1'b0;
        ctrl_valid = 1'b0;
        done       = 1'b0;
        pop_addr   = '0;
        for (int i = 0; i < STACK_DEPTH; i++)
            if (sp_q == SP_W'(i + 1)) pop_addr = stack_q[i];

        case (state_q)
            ST_IDLE: op_ready = reset_n;
            ST_EXEC: begin
                ctrl_valid = 1'b1;
                if (!bus.stall) begin
                    case (seq_op)
                        SEQ_NEXT: uaddr_d = uaddr_inc;
                        SEQ_JUMP: uaddr_d = target;
                        SEQ_BRC:  uaddr_d = bus.cond[csel] ? target : uaddr_inc;
                        SEQ_CALL: begin
                            if (sp_q == SP_W'(STACK_DEPTH)) begin
                                state_d = ST_FAULT;
                            end else begin
                                for (int i = 0; i < STACK_DEPTH; i++)
                                    if (sp_q == SP_W'(i)) stack_d[i] = uaddr_inc;
                                sp_d    = sp_q + SP_W'(1);
                                uaddr_d = target;
                            end
                        end
                        SEQ_RET: begin
                            if (sp_q == '0) begin
                                state_d = ST_FAULT;
                            end else begin
                                uaddr_d = pop_addr;
                                sp_d    = sp_q - SP_W'(1);
                            end
                        end
                        SEQ_END: begin
                            done     = 1'b1;
                            sp_d     = '0;
                            state_d  = ST_IDLE;
                            op_ready = reset_n;
                        end
                        default: state_d = ST_FAULT;
                    endcase
                end
            end
            ST_FAULT: begin
                if (bus.fault_clr) begin
                    state_d = ST_IDLE;
                    sp_d    = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // An accept on the END cycle dispatches straight into the next routine.
        accept = bus.op_valid && op_ready;
        if (accept) begin
            uaddr_d = lkp_vld ? lkp_addr : TRAP_ADDR;
            state_d = ST_EXEC;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            uaddr_q <= '0;
            sp_q    <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
        end else begin
            state_q <= state_d;
            uaddr_q <= uaddr_d;
            sp_q    <= sp_d;
            stack_q <= stack_d;
        end
    end

    assign bus.op_ready   = op_ready;
    assign bus.uaddr      = uaddr_q;
    assign bus.ctrl_valid = ctrl_valid;
    assign bus.ctrl_word  = ctrl_valid ? cw : '0;
    assign bus.done       = done;
    assign bus.illegal    = accept && !lkp_vld;
    assign bus.fault      = (state_q == ST_FAULT);
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_useq_sequencer.sv
// Directed bench for useq_sequencer: a small ROM image, linear steps and
// immediate assertions against hand-computed values.
module tb_useq_sequencer;
    import useq_pkg::*;

    localparam int UI_W = 27;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    logic [UI_W-1:0] rom [64];

    useq_sequencer_if #(.OPCODE_W(8), .UADDR_W(6), .CW_W(16), .NUM_COND(4)) bus ();

    useq_sequencer #(
        .OPCODE_W(8), .UADDR_W(6), .CW_W(16), .NUM_COND(4),
        .STACK_DEPTH(2), .TRAP_ADDR(6'h3F)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    assign bus.uinstr = rom[bus.uaddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [UI_W-1:0] mk(logic [2:0] op, logic [1:0] cs,
                                           logic [5:0] tg, logic [15:0] cw);
        return {op, cs, tg, cw};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic tbl_write(input logic [7:0] idx, input logic [5:0] addr);
        bus.tbl_we   = 1'b1;
        bus.tbl_idx  = idx;
        bus.tbl_addr = addr;
        bus.tbl_vld  = 1'b1;
        step();
        bus.tbl_we   = 1'b0;
    endtask

    task automatic offer(input logic [7:0] op);
        bus.op_valid = 1'b1;
        bus.opcode   = op;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = mk(SEQ_NEXT, 2'd0, 6'd0, 16'h0);
        rom[0]  = mk(SEQ_END,  2'd0, 6'd0,  16'h1000);
        rom[1]  = mk(SEQ_END,  2'd0, 6'd0,  16'h1111);
        rom[4]  = mk(SEQ_BRC,  2'd2, 6'd20, 16'h4444);
        rom[5]  = mk(SEQ_END,  2'd0, 6'd0,  16'h5555);
        rom[6]  = mk(SEQ_CALL, 2'd0, 6'd30, 16'h6666);
        rom[7]  = mk(SEQ_END,  2'd0, 6'd0,  16'h7777);
        rom[8]  = mk(SEQ_NEXT, 2'd0, 6'd0,  16'h0808);
        rom[9]  = mk(SEQ_NEXT, 2'd0, 6'd0,  16'h0909);
        rom[10] = mk(SEQ_END,  2'd0, 6'd0,  16'h0A0A);
        rom[20] = mk(SEQ_END,  2'd0, 6'd0,  16'h2020);
        rom[30] = mk(SEQ_RET,  2'd0, 6'd0,  16'h3030);
        rom[40] = mk(SEQ_CALL, 2'd0, 6'd41, 16'h4040);
        rom[41] = mk(SEQ_CALL, 2'd0, 6'd42, 16'h4141);
        rom[42] = mk(SEQ_CALL, 2'd0, 6'd43, 16'h4242);
        rom[50] = mk(SEQ_RET,  2'd0, 6'd0,  16'h5050);
        rom[51] = mk(3'd6,     2'd0, 6'd0,  16'h5151);
        rom[63] = mk(SEQ_END,  2'd0, 6'd0,  16'h3F3F);

        reset_n       = 1'b0;
        bus.op_valid  = 1'b1;
        bus.opcode    = 8'h02;
        bus.cond      = '0;
        bus.stall     = 1'b0;
        bus.fault_clr = 1'b0;
        bus.tbl_we    = 1'b0;
        bus.tbl_idx   = '0;
        bus.tbl_addr  = '0;
        bus.tbl_vld   = 1'b0;

        // Reset values
        #3;
        check("rst_op_ready", bus.op_ready, 0);
        check("rst_uaddr", bus.uaddr, 0);
        check("rst_ctrl_valid", bus.ctrl_valid, 0);
        check("rst_done", bus.done, 0);
        check("rst_illegal", bus.illegal, 0);
        check("rst_fault", bus.fault, 0);
        bus.op_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        step();

        // Legacy map 0x02 -> 1, ROM[1] = END
        offer(8'h02);
        check("t1_op_ready", bus.op_ready, 1);
        check("t1_illegal", bus.illegal, 0);
        step();
        bus.op_valid = 1'b0;
        check("t1_uaddr", bus.uaddr, 1);
        check("t1_ctrl_valid", bus.ctrl_valid, 1);
        check("t1_ctrl_word", bus.ctrl_word, 16'h1111);
        check("t1_done", bus.done, 1);
        step();
        check("t1_idle_cv", bus.ctrl_valid, 0);
        check("t1_idle_done", bus.done, 0);
        check("t1_idle_state", bus.dbg_state, ST_IDLE);

        // Write 0x10 -> 8 while offering 0x10: lookup sees the old (invalid) entry
        bus.tbl_we = 1'b1; bus.tbl_idx = 8'h10; bus.tbl_addr = 6'd8; bus.tbl_vld = 1'b1;
        offer(8'h10);
        check("t2_same_cycle_illegal", bus.illegal, 1);
        step();
        bus.tbl_we = 1'b0; bus.op_valid = 1'b0;
        check("t2_trap_uaddr", bus.uaddr, 6'h3F);
        check("t2_trap_cw", bus.ctrl_word, 16'h3F3F);
        check("t2_illegal_pulse", bus.illegal, 0);
        step();
        offer(8'h10);
        check("t2_illegal_new", bus.illegal, 0);
        step();
        bus.op_valid = 1'b0;
        check("t2_uaddr8", bus.uaddr, 8);
        check("t2_cw8", bus.ctrl_word, 16'h0808);
        check("t2_done8", bus.done, 0);
        step();
        check("t2_uaddr9", bus.uaddr, 9);
        check("t2_cw9", bus.ctrl_word, 16'h0909);
        step();
        check("t2_uaddr10", bus.uaddr, 10);
        check("t2_cw10", bus.ctrl_word, 16'h0A0A);
        check("t2_done10", bus.done, 1);
        step();
        check("t2_idle_cw", bus.ctrl_word, 0);

        // Branch at 4 on cond[2], plus stall
        tbl_write(8'h11, 6'd4);
        bus.cond = 4'b0100;
        offer(8'h11);
        step();
        bus.op_valid = 1'b0;
        check("t3_uaddr4", bus.uaddr, 4);
        bus.stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_stall_uaddr", bus.uaddr, 4);
            check("t3_stall_cv", bus.ctrl_valid, 1);
        end
        bus.stall = 1'b0;
        step();
        check("t3_taken", bus.uaddr, 20);
        check("t3_taken_cw", bus.ctrl_word, 16'h2020);
        step();
        bus.cond = 4'b1011;
        offer(8'h11);
        step();
        bus.op_valid = 1'b0;
        check("t3_uaddr4b", bus.uaddr, 4);
        step();
        check("t3_not_taken", bus.uaddr, 5);
        check("t3_not_taken_done", bus.done, 1);
        step();

        // CALL 30 from 6, RET -> 7
        tbl_write(8'h12, 6'd6);
        offer(8'h12);
        step();
        bus.op_valid = 1'b0;
        check("t4_uaddr6", bus.uaddr, 6);
        step();
        check("t4_call", bus.uaddr, 30);
        check("t4_call_cw", bus.ctrl_word, 16'h3030);
        step();
        check("t4_ret", bus.uaddr, 7);
        check("t4_ret_done", bus.done, 1);
        step();

        // Nested calls overflow the two-entry stack
        tbl_write(8'h13, 6'd40);
        offer(8'h13);
        step();
        bus.op_valid = 1'b0;
        check("t4_uaddr40", bus.uaddr, 40);
        step();
        check("t4_uaddr41", bus.uaddr, 41);
        step();
        check("t4_uaddr42", bus.uaddr, 42);
        offer(8'h01);
        step();
        check("t4_fault", bus.fault, 1);
        check("t4_fault_ready", bus.op_ready, 0);
        check("t4_fault_cv", bus.ctrl_valid, 0);
        check("t4_fault_uaddr", bus.uaddr, 42);
        step();
        check("t4_fault_hold", bus.dbg_state, ST_FAULT);
        check("t4_fault_hold_uaddr", bus.uaddr, 42);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        check("t4_clr_fault", bus.fault, 0);
        check("t4_clr_state", bus.dbg_state, ST_IDLE);
        check("t4_clr_ready", bus.op_ready, 1);
        bus.op_valid = 1'b0;

        // RET on an empty stack (pointer cleared by fault_clr) faults
        tbl_write(8'h14, 6'd50);
        offer(8'h14);
        step();
        bus.op_valid = 1'b0;
        check("t4_uaddr50", bus.uaddr, 50);
        step();
        check("t4_ret_empty_fault", bus.fault, 1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;

        // Reserved op faults
        tbl_write(8'h15, 6'd51);
        offer(8'h15);
        step();
        bus.op_valid = 1'b0;
        check("t4_uaddr51", bus.uaddr, 51);
        step();
        check("t4_reserved_fault", bus.fault, 1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;

        // Unmapped 0xAA traps, then back-to-back 0x01 on the END cycle
        offer(8'hAA);
        check("t5_illegal", bus.illegal, 1);
        step();
        check("t5_trap_uaddr", bus.uaddr, 6'h3F);
        check("t5_trap_done", bus.done, 1);
        offer(8'h01);
        check("t5_end_ready", bus.op_ready, 1);
        check("t5_end_illegal", bus.illegal, 0);
        step();
        bus.op_valid = 1'b0;
        check("t5_b2b_uaddr", bus.uaddr, 0);
        check("t5_b2b_cv", bus.ctrl_valid, 1);
        check("t5_b2b_cw", bus.ctrl_word, 16'h1000);
        step();

        // Asynchronous reset mid-routine
        offer(8'h01);
        step();
        bus.op_valid = 1'b0;
        tbl_write(8'h10, 6'd8);
        offer(8'h10);
        step();
        bus.op_valid = 1'b0;
        step();
        check("t6_uaddr9", bus.uaddr, 9);
        #2 reset_n = 1'b0;
        #1;
        check("t6_rst_uaddr", bus.uaddr, 0);
        check("t6_rst_cv", bus.ctrl_valid, 0);
        check("t6_rst_done", bus.done, 0);
        check("t6_rst_ready", bus.op_ready, 0);
        check("t6_rst_state", bus.dbg_state, ST_IDLE);
        step();
        check("t6_rst_done2", bus.done, 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        check("t6_post_ready", bus.op_ready, 1);
        check("t6_post_fault", bus.fault, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
